// File: rtl/intr_ctrl_if.sv
// CPU-side handshake of the interrupt controller.
// The controller (master) presents irq/irq_num; the CPU control unit (slave)
// answers with ack (accept) and ret (end of service).
interface intr_ctrl_if #(
  parameter int NW = 5
) ();
  logic          irq;
  logic [NW-1:0] irq_num;
  logic          ack;
  logic          ret;

  modport master (
    output irq,
    output irq_num,
    input  ack,
    input  ret
  );

  modport slave (
    input  irq,
    input  irq_num,
    output ack,
    output ret
  );
endinterface

// File: rtl/intr_ctrl.sv
// N-channel fixed-priority interrupt controller with nesting.
// Per-channel request (rz), in-service (rp) and mask registers; lower index
// means higher priority. Only a channel outranking every in-service channel
// may be presented to the CPU.
// Optional feature: define INTR_EDGE_EN for edge-triggered irq_in sources
// (a 0->1 edge of the synchronised source sets rz once); otherwise sources
// are level-sensitive and set rz every cycle they are high.
module intr_ctrl #(
  parameter int N  = 32,
  parameter int NW = 5
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic [N-1:0]  irq_in,
  input  logic          set_stb,
  input  logic [NW-1:0] set_num,
  input  logic          clr_stb,
  input  logic [NW-1:0] clr_num,
  input  logic          clr_all,
  input  logic          mask_wr,
  input  logic [N-1:0]  mask_in,
  output logic [N-1:0]  mask,
  output logic [N-1:0]  rz,
  output logic [N-1:0]  sz,
  output logic [N-1:0]  rp,
  intr_ctrl_if.master   cpu
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_load;

  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;
  logic [N-1:0]  w_src;

  logic [N-1:0]  r_rz;
  logic [N-1:0]  r_rp;
  logic [N-1:0]  r_mask;
  logic [NW-1:0] r_irq_num;

  logic [N-1:0]  w_sz;
  logic [N-1:0]  w_set_hit;
  logic [N-1:0]  w_clr_hit;
  logic [N-1:0]  w_grant;
  logic          w_ack_fire;
  logic [N-1:0]  w_rp_low;
  logic [N-1:0]  w_below;
  logic [N-1:0]  w_cand;
  logic          w_elig_valid;
  logic [NW-1:0] w_elig_idx;
  logic [N-1:0]  w_rz_next;
  logic [N-1:0]  w_rp_next;

  // Two-flop synchroniser for the asynchronous request sources
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef INTR_EDGE_EN
  logic [N-1:0] r_sync3;

  // Third flop remembers the previous synchronised level for edge detection
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_sync3 <= '0;
    end else begin
      r_sync3 <= r_sync2;
    end
  end

  assign w_src = r_sync2 & ~r_sync3;
`else
  assign w_src = r_sync2;
`endif

  assign w_sz       = r_rz & r_mask;
  assign w_ack_fire = (r_state == ST_REQ) && cpu.ack;

  // One-hot decode of the software strobes and the granted channel;
  // channel numbers >= N match no bit and are therefore ignored
  always_comb begin
    w_set_hit = '0;
    w_clr_hit = '0;
    w_grant   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_set_hit[i] = set_stb && (set_num == NW'(i));
      w_clr_hit[i] = clr_stb && (clr_num == NW'(i));
      w_grant[i]   = w_ack_fire && (r_irq_num == NW'(i));
    end
  end

  // Lowest set rp bit isolated; everything strictly below it may nest.
  // With rp=0 the subtraction wraps to all ones, i.e. every channel eligible.
  assign w_rp_low = r_rp & (~r_rp + N'(1));
  assign w_below  = w_rp_low - N'(1);
  assign w_cand   = w_sz & w_below;

  // Fixed priority pick: scan from the top so the lowest index wins
  always_comb begin
    w_elig_valid = |w_cand;
    w_elig_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_cand[N-1-k]) begin
        w_elig_idx = NW'(N - 1 - k);
      end
    end
  end

  // Sets beat individual clears; clr_all beats everything
  assign w_rz_next = clr_all ? '0 : ((w_src | w_set_hit) | (r_rz & ~(w_clr_hit | w_grant)));

  // ret retires the lowest set rp bit first, then an ack in the same cycle adds its channel
  assign w_rp_next = (cpu.ret ? (r_rp & ~w_rp_low) : r_rp) | w_grant;

  // Request, in-service and mask registers
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_rz   <= '0;
      r_rp   <= '0;
      r_mask <= '0;
    end else begin
      r_rz <= w_rz_next;
      r_rp <= w_rp_next;
      if (mask_wr) begin
        r_mask <= mask_in;
      end
    end
  end

  // Handshake FSM state register
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: present, then either grant (via GAP) or withdraw
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig_valid) begin
          w_state_next = ST_REQ;
          w_load       = 1'b1;
        end
      end
      ST_REQ: begin
        if (cpu.ack) begin
          w_state_next = ST_GAP;
        end else if (!w_sz[r_irq_num]) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Channel number is captured on entry to REQ and frozen until the next capture
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_irq_num <= '0;
    end else if (w_load) begin
      r_irq_num <= w_elig_idx;
    end
  end

  assign cpu.irq     = (r_state == ST_REQ);
  assign cpu.irq_num = r_irq_num;
  assign mask        = r_mask;
  assign rz          = r_rz;
  assign sz          = w_sz;
  assign rp          = r_rp;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: a few directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_intr_ctrl;
  localparam int N  = 32;
  localparam int NW = 5;

  logic          clk_sys = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          set_stb;
  logic [NW-1:0] set_num;
  logic          clr_stb;
  logic [NW-1:0] clr_num;
  logic          clr_all;
  logic          mask_wr;
  logic [N-1:0]  mask_in;
  logic [N-1:0]  mask;
  logic [N-1:0]  rz;
  logic [N-1:0]  sz;
  logic [N-1:0]  rp;

  intr_ctrl_if #(.NW(NW)) cpu_if ();

  intr_ctrl #(.N(N), .NW(NW)) u_dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .irq_in  (irq_in),
    .set_stb (set_stb),
    .set_num (set_num),
    .clr_stb (clr_stb),
    .clr_num (clr_num),
    .clr_all (clr_all),
    .mask_wr (mask_wr),
    .mask_in (mask_in),
    .mask    (mask),
    .rz      (rz),
    .sz      (sz),
    .rp      (rp),
    .cpu     (cpu_if.master)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [N-1:0] m_rz   = '0;
  logic [N-1:0] m_rp   = '0;
  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_h1   = '0;   // irq_in as seen 1, 2, 3 edges ago
  logic [N-1:0] m_h2   = '0;
  logic [N-1:0] m_h3   = '0;
  bit           m_irq  = 1'b0;
  bit           m_gap  = 1'b0;
  int           m_num  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next model state from the inputs currently driven
  task automatic model_step();
    logic [N-1:0] n_rz;
    logic [N-1:0] n_rp;
    int  p;
    int  e;
    bit  fire;
    bit  src;
    bit  set_i;
    bit  clr_i;
    if (rst) begin
      m_rz = '0; m_rp = '0; m_mask = '0;
      m_h1 = '0; m_h2 = '0; m_h3 = '0;
      m_irq = 1'b0; m_gap = 1'b0; m_num = 0;
      return;
    end
    p = N;
    for (int i = N - 1; i >= 0; i--) if (m_rp[i]) p = i;
    e = -1;
    for (int i = p - 1; i >= 0; i--) if (m_rz[i] && m_mask[i]) e = i;
    fire = m_irq && cpu_if.ack;
    for (int i = 0; i < N; i++) begin
`ifdef INTR_EDGE_EN
      src = m_h2[i] && !m_h3[i];
`else
      src = m_h2[i];
`endif
      set_i = src || (set_stb && int'(set_num) == i);
      clr_i = (clr_stb && int'(clr_num) == i) || (fire && m_num == i);
      if (clr_all)    n_rz[i] = 1'b0;
      else if (set_i) n_rz[i] = 1'b1;
      else if (clr_i) n_rz[i] = 1'b0;
      else            n_rz[i] = m_rz[i];
    end
    n_rp = m_rp;
    if (cpu_if.ret && p < N) n_rp[p] = 1'b0;
    if (fire) n_rp[m_num] = 1'b1;
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_irq) begin
      if (cpu_if.ack) begin
        m_irq = 1'b0;
        m_gap = 1'b1;
      end else if (!(m_rz[m_num] && m_mask[m_num])) begin
        m_irq = 1'b0;
      end
    end else if (e >= 0) begin
      m_irq = 1'b1;
      m_num = e;
    end
    if (mask_wr) m_mask = mask_in;
    m_h3 = m_h2;
    m_h2 = m_h1;
    m_h1 = irq_in;
    m_rz = n_rz;
    m_rp = n_rp;
  endtask

  task automatic compare_all();
    chk("rz", 64'(rz), 64'(m_rz));
    chk("rp", 64'(rp), 64'(m_rp));
    chk("mask", 64'(mask), 64'(m_mask));
    chk("sz", 64'(sz), 64'(m_rz & m_mask));
    chk("irq", 64'(cpu_if.irq), 64'(m_irq));
    chk("irq_num", 64'(cpu_if.irq_num), 64'(m_num));
  endtask

  task automatic step();
    model_step();
    @(posedge clk_sys);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; set_stb = 1'b0; clr_stb = 1'b0; clr_all = 1'b0;
    mask_wr = 1'b0; cpu_if.ack = 1'b0; cpu_if.ret = 1'b0;
  endtask

  task automatic drive_random();
    idle_inputs();
    rst     = ($urandom_range(0, 599) == 0);
    set_stb = ($urandom_range(0, 3) == 0);
    set_num = NW'($urandom_range(0, N - 1));
    clr_stb = ($urandom_range(0, 4) == 0);
    clr_num = NW'($urandom_range(0, N - 1));
    clr_all = ($urandom_range(0, 79) == 0);
    mask_wr = ($urandom_range(0, 39) == 0);
    mask_in = ($urandom_range(0, 2) == 0) ? '1 : N'($urandom() | $urandom());
    if ($urandom_range(0, 11) == 0) irq_in[$urandom_range(0, N - 1)] ^= 1'b1;
    if ($urandom_range(0, 29) == 0) irq_in = '0;
    cpu_if.ack = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
    cpu_if.ret = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    idle_inputs();
    set_num = '0; clr_num = '0; mask_in = '0;

    // Reset with every source high, then let the sources resynchronise
    irq_in = '1;
    rst = 1'b1;
    step();
    chk("rst_rz", 64'(rz), 64'h0);
    chk("rst_irq", 64'(cpu_if.irq), 64'h0);
    rst = 1'b0;
    repeat (4) step();

    // Clean restart, all channels enabled, software request on channel 5
    irq_in = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mask_wr = 1'b1; mask_in = '1;
    step();
    mask_wr = 1'b0;
    set_stb = 1'b1; set_num = NW'(5);
    step();
    set_stb = 1'b0;
    step();
    chk("t2_irq", 64'(cpu_if.irq), 64'h1);
    chk("t2_num", 64'(cpu_if.irq_num), 64'd5);
    cpu_if.ack = 1'b1;
    step();
    cpu_if.ack = 1'b0;
    chk("t2_rp", 64'(rp), 64'h20);
    chk("t2_rz", 64'(rz), 64'h0);
    chk("t2_gap", 64'(cpu_if.irq), 64'h0);

    // Nesting: channel 9 is blocked by in-service 5, channel 2 may nest
    set_stb = 1'b1; set_num = NW'(9);
    step();
    set_stb = 1'b0;
    repeat (2) step();
    chk("t3_blocked", 64'(cpu_if.irq), 64'h0);
    set_stb = 1'b1; set_num = NW'(2);
    step();
    set_stb = 1'b0;
    step();
    chk("t3_irq", 64'(cpu_if.irq), 64'h1);
    chk("t3_num", 64'(cpu_if.irq_num), 64'd2);
    cpu_if.ack = 1'b1;
    step();
    cpu_if.ack = 1'b0;
    chk("t3_rp_nest", 64'(rp), 64'h24);
    cpu_if.ret = 1'b1;
    step();
    chk("t3_rp_ret1", 64'(rp), 64'h20);
    step();
    cpu_if.ret = 1'b0;
    chk("t3_rp_ret2", 64'(rp), 64'h0);
    step();
    chk("t3_ch9", 64'(cpu_if.irq_num), 64'd9);
    chk("t3_ch9_irq", 64'(cpu_if.irq), 64'h1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
